// File: rtl/register_file_pkg.sv
// Shared constants for the RV32 integer register file: widths, the x0 index
// and the readOrWrite mode encodings.
package register_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef logic [XLEN-1:0]      xreg_t;
  typedef logic [REG_IDX_W-1:0] xidx_t;

  // True when an index names the hardwired-zero register.
  function automatic logic is_zero_reg(input xidx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/write-back side bundle of the register file: one write port and two
// combinational read ports.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_IDX_W
);

  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] Write;
  logic              readOrWrite;
  logic [DATA_W-1:0] RegOutput1;
  logic [DATA_W-1:0] RegOutput2;

  modport master (
    output rd, rs1, rs2, Write, readOrWrite,
    input  RegOutput1, RegOutput2
  );

  modport slave (
    input  rd, rs1, rs2, Write, readOrWrite,
    output RegOutput1, RegOutput2
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: selects an entry of the storage array, forcing
// index 0 to read as zero regardless of what the array holds there.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_IDX_W,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [NREGS],
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (addr != ADDR_W'(ZERO_REG)) begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// RV32 integer register file: 32 x 32-bit, two combinational read ports, one
// synchronous write port, x0 hardwired to zero, synchronous reset clears all.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [NREGS-1:0]  we_vec;
  logic              write_en;
  logic [ADDR_W-1:0] rs_addr [2];
  logic [DATA_W-1:0] rs_data [2];

  assign write_en = (bus.readOrWrite == RW_WRITE);

  // Per-entry write decode; entry 0 never gets an enable, so x0 writes vanish.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_we
      if (gi == 0) begin : g_zero
        assign we_vec[gi] = 1'b0;
      end else begin : g_live
        assign we_vec[gi] = write_en && (bus.rd == ADDR_W'(gi));
      end
    end
  endgenerate

  // Reset wins over a write presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_vec[i]) begin
          regs_reg[i] <= bus.Write;
        end
      end
    end
  end

  assign rs_addr[0] = bus.rs1;
  assign rs_addr[1] = bus.rs2;

  // No write-to-read bypass: reads see the array as it stood before the edge.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      register_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
      ) u_port (
        .addr (rs_addr[gi]),
        .regs (regs_reg),
        .data (rs_data[gi])
      );
    end
  endgenerate

  assign bus.RegOutput1 = rs_data[0];
  assign bus.RegOutput2 = rs_data[1];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: x0 behaviour, read-only
// cycles, same-register read/write ordering, reset priority and a full sweep.
module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  register_file_if #(.DATA_W(XLEN), .ADDR_W(REG_IDX_W)) rf_if ();

  register_file #(.DATA_W(XLEN), .ADDR_W(REG_IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    rf_if.rd          = idx;
    rf_if.Write       = data;
    rf_if.readOrWrite = RW_WRITE;
    tick();
    rf_if.readOrWrite = RW_READ;
    $display("write x%0d <= %h", idx, data);
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    rf_if.rs1 = a;
    rf_if.rs2 = b;
    #1;
  endtask

  initial begin
    rf_if.rd          = '0;
    rf_if.rs1         = '0;
    rf_if.rs2         = '0;
    rf_if.Write       = '0;
    rf_if.readOrWrite = RW_READ;
    #1;
    check("x0_before_reset", rf_if.RegOutput1, 32'h0);

    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset");
    rd2(5'd1, 5'd31);
    check("reset_x1", rf_if.RegOutput1, 32'h0);
    check("reset_x31", rf_if.RegOutput2, 32'h0);

    // Write to x0 is discarded
    wr(5'd0, 32'd5);
    rd2(5'd0, 5'd0);
    check("x0_write_discard_p1", rf_if.RegOutput1, 32'h0);
    check("x0_write_discard_p2", rf_if.RegOutput2, 32'h0);

    // Write x7, then a read-only cycle must not alter it
    wr(5'd7, 32'd10);
    rd2(5'd0, 5'd7);
    check("x7_write", rf_if.RegOutput2, 32'd10);
    rf_if.rd          = 5'd7;
    rf_if.Write       = 32'd1;
    rf_if.readOrWrite = RW_READ;
    tick();
    $display("read-only cycle rd=7 Write=1");
    check("x7_readonly_hold", rf_if.RegOutput2, 32'd10);

    // Second register, both ports
    wr(5'd8, 32'd2);
    rd2(5'd7, 5'd8);
    check("x8_p2", rf_if.RegOutput2, 32'd2);
    check("x7_p1", rf_if.RegOutput1, 32'd10);
    rd2(5'd8, 5'd8);
    check("same_idx_p1", rf_if.RegOutput1, 32'd2);
    check("same_idx_p2", rf_if.RegOutput2, 32'd2);

    // Same-register read/write: old value before edge, new after
    wr(5'd3, 32'hAAAA_AAAA);
    rf_if.rd          = 5'd3;
    rf_if.rs1         = 5'd3;
    rf_if.Write       = 32'h1234_5678;
    rf_if.readOrWrite = RW_WRITE;
    #1;
    check("no_bypass_before", rf_if.RegOutput1, 32'hAAAA_AAAA);
    tick();
    rf_if.readOrWrite = RW_READ;
    $display("write x3 <= 12345678");
    check("new_after_edge", rf_if.RegOutput1, 32'h1234_5678);

    // Fill x1..x31, then reset with a competing write to x4
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'h0101_0101 * i + 32'h100);
    end
    rd2(5'd4, 5'd31);
    check("fill_x4", rf_if.RegOutput1, 32'h0404_0504);
    check("fill_x31", rf_if.RegOutput2, 32'h1F1F_201F);
    rst               = 1'b1;
    rf_if.rd          = 5'd4;
    rf_if.Write       = 32'hFFFF_FFFF;
    rf_if.readOrWrite = RW_WRITE;
    tick();
    rst               = 1'b0;
    rf_if.readOrWrite = RW_READ;
    $display("reset with concurrent write x4 <= ffffffff");
    for (int i = 0; i < 32; i++) begin
      rd2(5'(i), 5'(31 - i));
      check($sformatf("rst_clear_p1_x%0d", i), rf_if.RegOutput1, 32'h0);
      check($sformatf("rst_clear_p2_x%0d", 31 - i), rf_if.RegOutput2, 32'h0);
    end

    // Operation resumes right after reset
    wr(5'd5, 32'hCAFE_F00D);
    rd2(5'd5, 5'd4);
    check("resume_x5", rf_if.RegOutput1, 32'hCAFE_F00D);
    check("resume_x4_zero", rf_if.RegOutput2, 32'h0);

    // Full sweep: x[i] = i*3
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 32'(i * 3));
    end
    for (int i = 0; i < 32; i++) begin
      rd2(5'(i), 5'(i));
      check($sformatf("sweep_p1_x%0d", i), rf_if.RegOutput1, (i == 0) ? 32'h0 : 32'(i * 3));
      check($sformatf("sweep_p2_x%0d", i), rf_if.RegOutput2, (i == 0) ? 32'h0 : 32'(i * 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
